// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment readback path.
// Contents: segment bit indices and masks, the sixteen glyph patterns the
// encoder recognises, and the tracking FSM state type.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Segment bit positions on the seg bus
  localparam int unsigned SEG_TOP = 0;
  localparam int unsigned SEG_RT  = 1;
  localparam int unsigned SEG_RB  = 2;
  localparam int unsigned SEG_BOT = 3;
  localparam int unsigned SEG_LB  = 4;
  localparam int unsigned SEG_LT  = 5;
  localparam int unsigned SEG_MID = 6;

  localparam logic [SEG_W-1:0] S_T  = SEG_W'(1) << SEG_TOP;
  localparam logic [SEG_W-1:0] S_RT = SEG_W'(1) << SEG_RT;
  localparam logic [SEG_W-1:0] S_RB = SEG_W'(1) << SEG_RB;
  localparam logic [SEG_W-1:0] S_B  = SEG_W'(1) << SEG_BOT;
  localparam logic [SEG_W-1:0] S_LB = SEG_W'(1) << SEG_LB;
  localparam logic [SEG_W-1:0] S_LT = SEG_W'(1) << SEG_LT;
  localparam logic [SEG_W-1:0] S_M  = SEG_W'(1) << SEG_MID;

  // Glyph patterns (lit = 1), hex value noted per entry
  localparam logic [SEG_W-1:0] PAT_0 = S_T | S_RT | S_RB | S_B | S_LB | S_LT;        // 3F
  localparam logic [SEG_W-1:0] PAT_1 = S_RT | S_RB;                                  // 06
  localparam logic [SEG_W-1:0] PAT_2 = S_T | S_RT | S_B | S_LB | S_M;                // 5B
  localparam logic [SEG_W-1:0] PAT_3 = S_T | S_RT | S_RB | S_B | S_M;                // 4F
  localparam logic [SEG_W-1:0] PAT_4 = S_RT | S_RB | S_LT | S_M;                     // 66
  localparam logic [SEG_W-1:0] PAT_5 = S_T | S_RB | S_B | S_LT | S_M;                // 6D
  localparam logic [SEG_W-1:0] PAT_6 = S_T | S_RB | S_B | S_LB | S_LT | S_M;         // 7D
  localparam logic [SEG_W-1:0] PAT_7 = S_T | S_RT | S_RB;                            // 07
  localparam logic [SEG_W-1:0] PAT_8 = S_T | S_RT | S_RB | S_B | S_LB | S_LT | S_M;  // 7F
  localparam logic [SEG_W-1:0] PAT_9 = S_T | S_RT | S_RB | S_B | S_LT | S_M;         // 6F
  localparam logic [SEG_W-1:0] PAT_A = S_T | S_RT | S_RB | S_LB | S_LT | S_M;        // 77
  localparam logic [SEG_W-1:0] PAT_B = S_B | S_LB;                                   // 18
  localparam logic [SEG_W-1:0] PAT_C = S_T | S_B | S_M;                              // 49
  localparam logic [SEG_W-1:0] PAT_D = S_LB | S_LT;                                  // 30
  localparam logic [SEG_W-1:0] PAT_E = S_T | S_B;                                    // 09
  localparam logic [SEG_W-1:0] PAT_F = S_T | S_RT | S_B;                             // 0B

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    COMMIT,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_readback_encoder_if.sv
// Segment-bus sampling interface for seg7_readback_encoder.
// master: drives seg/dig_sel/in_valid and observes the decoded results.
// slave : the readback encoder itself.
interface seg7_readback_encoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    in_valid;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_ok;
  logic                    upd;
  logic                    pat_err;
  logic                    sel_err;

  modport master (
    output seg, dig_sel, in_valid,
    input  value, digit_ok, upd, pat_err, sel_err
  );

  modport slave (
    input  seg, dig_sel, in_valid,
    output value, digit_ok, upd, pat_err, sel_err
  );
endinterface

// File: rtl/seg7_pattern_encoder.sv
// Combinational segment-pattern to nibble lookup.
// Ports: pat_i (7-bit pattern, lit = 1), hit_c (pattern is a known glyph),
//        nib_c (encoded nibble, 0 when no hit).
module seg7_pattern_encoder
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat_i,
  output logic             hit_c,
  output logic [NIB_W-1:0] nib_c
);

  always_comb begin
    hit_c = 1'b1;
    nib_c = '0;
    case (pat_i)
      PAT_0:   nib_c = 4'h0;
      PAT_1:   nib_c = 4'h1;
      PAT_2:   nib_c = 4'h2;
      PAT_3:   nib_c = 4'h3;
      PAT_4:   nib_c = 4'h4;
      PAT_5:   nib_c = 4'h5;
      PAT_6:   nib_c = 4'h6;
      PAT_7:   nib_c = 4'h7;
      PAT_8:   nib_c = 4'h8;
      PAT_9:   nib_c = 4'h9;
      PAT_A:   nib_c = 4'hA;
      PAT_B:   nib_c = 4'hB;
      PAT_C:   nib_c = 4'hC;
      PAT_D:   nib_c = 4'hD;
      PAT_E:   nib_c = 4'hE;
      PAT_F:   nib_c = 4'hF;
      default: hit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback_encoder.sv
// Seven-segment readback encoder: samples the multiplexed segment bus,
// qualifies each (pattern, digit) pair by STABLE_CYCLES identical valid
// samples, encodes it and stores the nibble in that digit's slot.
// Ports: clk, rst (synchronous, active-high), bus (slave modport):
//   seg/dig_sel/in_valid in; value, digit_ok, upd, pat_err, sel_err out.
// Timing: value/digit_ok change one clock after the edge that samples the
// last qualifying sample; upd pulses one clock after that.
// Build option: SEG_ACTIVE_LOW_EN inverts seg at the input (0 = lit).
module seg7_readback_encoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input logic                    clk,
  input logic                    rst,
  seg7_readback_encoder_if.slave bus
);

  localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEG_W-1:0]      cur_pat_q, cur_pat_d;
  logic [NUM_DIGITS-1:0] cur_sel_q, cur_sel_d;
  logic [VAL_W-1:0]      value_q, value_d;
  logic [NUM_DIGITS-1:0] ok_q, ok_d;
  logic                  chg_q, chg_d;
  logic                  upd_q, upd_d;
  logic                  pat_err_q, pat_err_d;
  logic                  sel_err_q, sel_err_d;

  logic [SEG_W-1:0]      seg_c;
  logic                  sel_ok_c;
  logic                  same_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  hit_c;
  logic [NIB_W-1:0]      nib_c;

  // Input polarity normalisation
`ifdef SEG_ACTIVE_LOW_EN
  assign seg_c = ~bus.seg;
`else
  assign seg_c = bus.seg;
`endif

  assign sel_ok_c  = $onehot(bus.dig_sel);
  assign same_c    = (seg_c == cur_pat_q) && (bus.dig_sel == cur_sel_q);
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  seg7_pattern_encoder u_enc (
    .pat_i (cur_pat_q),
    .hit_c (hit_c),
    .nib_c (nib_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_pat_q <= '0;
      cur_sel_q <= '0;
      value_q   <= '0;
      ok_q      <= '0;
      chg_q     <= 1'b0;
      upd_q     <= 1'b0;
      pat_err_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_pat_q <= cur_pat_d;
      cur_sel_q <= cur_sel_d;
      value_q   <= value_d;
      ok_q      <= ok_d;
      chg_q     <= chg_d;
      upd_q     <= upd_d;
      pat_err_q <= pat_err_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Next-state, commit and error logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_pat_d = cur_pat_q;
    cur_sel_d = cur_sel_q;
    value_d   = value_q;
    ok_d      = ok_q;
    chg_d     = 1'b0;
    upd_d     = chg_q;
    pat_err_d = pat_err_q;
    sel_err_d = sel_err_q;

    // The commit uses the latched pair, so a new sample this cycle can
    // still be latched below without disturbing the write.
    if (state_q == COMMIT) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (cur_sel_q[i]) begin
          if (hit_c) begin
            value_d[NIB_W*i +: NIB_W] = nib_c;
            ok_d[i] = 1'b1;
            chg_d   = !ok_q[i] || (value_q[NIB_W*i +: NIB_W] != nib_c);
          end else begin
            ok_d[i]   = 1'b0;
            pat_err_d = 1'b1;
          end
        end
      end
    end

    if (bus.in_valid && !sel_ok_c) begin
      sel_err_d = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else if (bus.in_valid && (state_q == TRACK) && same_c) begin
      cnt_d = cnt_inc_c;
      if (cnt_inc_c == CNT_W'(STABLE_CYCLES)) state_d = COMMIT;
    end else if (bus.in_valid && (state_q != IDLE) && same_c) begin
      state_d = HOLD;
    end else if (bus.in_valid) begin
      // New pattern or digit: restart qualification
      cur_pat_d = seg_c;
      cur_sel_d = bus.dig_sel;
      cnt_d     = CNT_W'(1);
      state_d   = (STABLE_CYCLES == 1) ? COMMIT : TRACK;
    end else if (state_q == COMMIT) begin
      state_d = HOLD;
    end
  end

  assign bus.value    = value_q;
  assign bus.digit_ok = ok_q;
  assign bus.upd      = upd_q;
  assign bus.pat_err  = pat_err_q;
  assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_seg7_readback_encoder.sv
// Directed bench for seg7_readback_encoder (4 digits, 4 stable cycles).
// Rows hold one bus sample for a number of clocks, then compare the outputs
// and the number of upd pulses seen during those clocks.
module tb_seg7_readback_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg7_readback_encoder_if #(.NUM_DIGITS(4)) bus ();

  seg7_readback_encoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic        vld;
    int          cyc;
    logic [15:0] val;
    logic [3:0]  ok;
    logic        perr;
    logic        serr;
    int          upds;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;
  int n_upd;

  function automatic logic [6:0] drv(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] val, input logic [3:0] ok,
                            input logic perr, input logic serr);
    check({tag, " value"},    32'(bus.value),    32'(val));
    check({tag, " digit_ok"}, 32'(bus.digit_ok), 32'(ok));
    check({tag, " pat_err"},  32'(bus.pat_err),  32'(perr));
    check({tag, " sel_err"},  32'(bus.sel_err),  32'(serr));
  endtask

  initial begin
    // seg, sel, vld, cycles, value, digit_ok, pat_err, sel_err, upd pulses
    tbl[0]  = '{7'h4F, 4'b0001, 1'b1, 4, 16'h0000, 4'h0, 1'b0, 1'b0, 0};
    tbl[1]  = '{7'h00, 4'b0000, 1'b0, 3, 16'h0003, 4'h1, 1'b0, 1'b0, 1};
    tbl[2]  = '{7'h77, 4'b0001, 1'b1, 6, 16'h000A, 4'h1, 1'b0, 1'b0, 1};
    tbl[3]  = '{7'h18, 4'b0010, 1'b1, 6, 16'h00BA, 4'h3, 1'b0, 1'b0, 1};
    tbl[4]  = '{7'h49, 4'b0100, 1'b1, 6, 16'h0CBA, 4'h7, 1'b0, 1'b0, 1};
    tbl[5]  = '{7'h30, 4'b1000, 1'b1, 6, 16'hDCBA, 4'hF, 1'b0, 1'b0, 1};
    tbl[6]  = '{7'h77, 4'b0001, 1'b1, 6, 16'hDCBA, 4'hF, 1'b0, 1'b0, 0};
    tbl[7]  = '{7'h18, 4'b0010, 1'b1, 6, 16'hDCBA, 4'hF, 1'b0, 1'b0, 0};
    tbl[8]  = '{7'h49, 4'b0100, 1'b1, 6, 16'hDCBA, 4'hF, 1'b0, 1'b0, 0};
    tbl[9]  = '{7'h30, 4'b1000, 1'b1, 6, 16'hDCBA, 4'hF, 1'b0, 1'b0, 0};
    tbl[10] = '{7'h7F, 4'b0001, 1'b1, 3, 16'hDCBA, 4'hF, 1'b0, 1'b0, 0};
    tbl[11] = '{7'h6F, 4'b0001, 1'b1, 1, 16'hDCBA, 4'hF, 1'b0, 1'b0, 0};
    tbl[12] = '{7'h7F, 4'b0001, 1'b1, 4, 16'hDCBA, 4'hF, 1'b0, 1'b0, 0};
    tbl[13] = '{7'h00, 4'b0000, 1'b0, 3, 16'hDCB8, 4'hF, 1'b0, 1'b0, 1};
    tbl[14] = '{7'h00, 4'b0100, 1'b1, 4, 16'hDCB8, 4'hF, 1'b0, 1'b0, 0};
    tbl[15] = '{7'h00, 4'b0000, 1'b0, 3, 16'hDCB8, 4'hB, 1'b1, 1'b0, 0};
    tbl[16] = '{7'h06, 4'b0001, 1'b1, 3, 16'hDCB8, 4'hB, 1'b1, 1'b0, 0};
    tbl[17] = '{7'h06, 4'b0011, 1'b1, 1, 16'hDCB8, 4'hB, 1'b1, 1'b1, 0};
    tbl[18] = '{7'h06, 4'b0001, 1'b1, 1, 16'hDCB8, 4'hB, 1'b1, 1'b1, 0};
    tbl[19] = '{7'h00, 4'b0000, 1'b0, 3, 16'hDCB8, 4'hB, 1'b1, 1'b1, 0};
    tbl[20] = '{7'h5B, 4'b0010, 1'b1, 2, 16'hDCB8, 4'hB, 1'b1, 1'b1, 0};
    tbl[21] = '{7'h00, 4'b0000, 1'b0, 2, 16'hDCB8, 4'hB, 1'b1, 1'b1, 0};
    tbl[22] = '{7'h5B, 4'b0010, 1'b1, 2, 16'hDCB8, 4'hB, 1'b1, 1'b1, 0};
    tbl[23] = '{7'h00, 4'b0000, 1'b0, 3, 16'hDC28, 4'hB, 1'b1, 1'b1, 1};

    bus.seg      = '0;
    bus.dig_sel  = '0;
    bus.in_valid = 1'b0;

    // Reset state
    tick();
    tick();
    check_outs("reset", 16'h0000, 4'h0, 1'b0, 1'b0);
    check("reset upd", 32'(bus.upd), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.seg      = drv(tbl[i].seg);
      bus.dig_sel  = tbl[i].sel;
      bus.in_valid = tbl[i].vld;
      n_upd = 0;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        tick();
        if (bus.upd) n_upd++;
      end
      check_outs($sformatf("row%0d", i), tbl[i].val, tbl[i].ok, tbl[i].perr, tbl[i].serr);
      check($sformatf("row%0d upd_count", i), 32'(n_upd), 32'(tbl[i].upds));
    end

    // Reset asserted mid-TRACK with a valid sample still on the bus
    bus.seg      = drv(7'h06);
    bus.dig_sel  = 4'b0001;
    bus.in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_outs("midrst", 16'h0000, 4'h0, 1'b0, 1'b0);
    check("midrst upd", 32'(bus.upd), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    // Digit 0 shows "1" after reset; exact value/upd latency
    bus.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    bus.in_valid = 1'b0;
    check("post4 value", 32'(bus.value), 32'h0000);
    tick();
    check("lat1 value", 32'(bus.value), 32'h0001);
    check("lat1 digit_ok", 32'(bus.digit_ok), 32'h1);
    check("lat1 upd", 32'(bus.upd), 32'd0);
    tick();
    check("lat2 upd", 32'(bus.upd), 32'd1);
    tick();
    check("lat3 upd", 32'(bus.upd), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
